// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider (signed/unsigned) for the EX stage, result {remainder, quotient}.
// Latency WIDTH+1 edges from an accepted start (2 for a zero divisor); result is held until start drops.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);

    typedef enum logic [1:0] {IDLE, DZERO, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic [CNT_W-1:0] cnt;

    logic             sign1;
    logic             sign2;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign sign1  = signed_div_i & opdata1_i[WIDTH-1];
    assign sign2  = signed_div_i & opdata2_i[WIDTH-1];

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dsr};
    assign borrow = diff[WIDTH+1];
    assign q_next = {dvd[WIDTH-2:0], ~borrow};
    assign r_next = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_fix  = q_neg ? -q_next : q_next;
    assign r_fix  = r_neg ? -r_next : r_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            dvd        <= '0;
            dsr        <= '0;
            rem        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            cnt        <= '0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == '0) begin
                            state <= DZERO;
                        end else begin
                            state <= BUSY;
                            dvd   <= sign1 ? -opdata1_i : opdata1_i;
                            dsr   <= sign2 ? -opdata2_i : opdata2_i;
                            rem   <= '0;
                            q_neg <= sign1 ^ sign2;
                            r_neg <= sign1;
                            cnt   <= '0;
                        end
                    end
                end
                DZERO: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state      <= DONE;
                        result_o   <= '0;
                        ready_o    <= 1'b1;
                        div_zero_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        dvd <= q_next;
                        rem <= r_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state      <= DONE;
                            busy_o     <= 1'b0;
                            result_o   <= {r_fix, q_fix};
                            ready_o    <= 1'b1;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!start_i || annul_i) begin
                        state      <= IDLE;
                        result_o   <= '0;
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a 32-bit instance for most scenarios, an 8-bit one for width scaling.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;
    logic        div_zero;

    logic        signed8;
    logic [7:0]  op1_8;
    logic [7:0]  op2_8;
    logic        start8;
    logic        annul8;
    logic [15:0] result8;
    logic        ready8;
    logic        busy8;
    logic        div_zero8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(32), .CNT_W(7)) dut (
        .clk(clk), .resetn(resetn), .signed_div_i(signed_div),
        .opdata1_i(opdata1), .opdata2_i(opdata2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready), .busy_o(busy), .div_zero_o(div_zero)
    );

    div_iter_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .resetn(resetn), .signed_div_i(signed8),
        .opdata1_i(op1_8), .opdata2_i(op2_8), .start_i(start8), .annul_i(annul8),
        .result_o(result8), .ready_o(ready8), .busy_o(busy8), .div_zero_o(div_zero8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start with the given operands and count edges until ready (edges=-1 on timeout).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int edges, output int busy_cycles);
        signed_div  = sgn;
        opdata1     = a;
        opdata2     = b;
        start       = 1'b1;
        edges       = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (busy) busy_cycles++;
            if (ready) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
        signed8 = 1'b0; op1_8 = '0; op2_8 = '0; start8 = 1'b0; annul8 = 1'b0;
        repeat (2) tick();
        total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int e, bc;
        run_div(1'b0, 32'd100, 32'd7, e, bc);
        total++; if (e !== 33) begin bad++; $display("FAIL udiv_latency got=%0d exp=33", e); end
        total++; if (bc !== 32) begin bad++; $display("FAIL udiv_busy_cycles got=%0d exp=32", bc); end
        total++; if (result !== {32'd2, 32'd14}) begin bad++; $display("FAIL udiv_result got=%h exp=%h", result, {32'd2, 32'd14}); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL udiv_dz got=%b exp=0", div_zero); end
        opdata1 = 32'hDEAD_BEEF;
        opdata2 = 32'd3;
        tick();
        total++; if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL udiv_hold ready=%b result=%h exp ready=1 result=%h", ready, result, {32'd2, 32'd14});
        end
        release_start();
        total++; if (ready !== 1'b0 || result !== 64'd0) begin
            bad++; $display("FAIL udiv_release ready=%b result=%h exp ready=0 result=0", ready, result);
        end
    endtask

    task automatic test_signed();
        int e, bc;
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2, e, bc);
        total++; if (result !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL sdiv_neg_dividend got=%h exp=ffffffff_fffffffd", result);
        end
        release_start();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, e, bc);
        total++; if (e !== 33) begin bad++; $display("FAIL sdiv_latency got=%0d exp=33", e); end
        total++; if (result !== {32'h1, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL sdiv_neg_divisor got=%h exp=00000001_fffffffd", result);
        end
        release_start();
    endtask

    task automatic test_div_zero();
        int e, bc;
        run_div(1'b0, 32'h1234, 32'h0, e, bc);
        total++; if (e !== 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", e); end
        total++; if (bc !== 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL dz_result got=%h exp=0", result); end
        release_start();
        total++; if (ready !== 1'b0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL dz_release ready=%b dz=%b exp 0 0", ready, div_zero);
        end
    endtask

    task automatic test_boundary();
        int e, bc;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
        total++; if (result !== {32'h0, 32'h8000_0000}) begin
            bad++; $display("FAIL sdiv_overflow got=%h exp=00000000_80000000", result);
        end
        release_start();
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, e, bc);
        total++; if (result !== {32'hF, 32'h0FFF_FFFF}) begin
            bad++; $display("FAIL udiv_large got=%h exp=0000000f_0fffffff", result);
        end
        release_start();
    endtask

    task automatic test_annul();
        int e, bc;
        bit seen_ready;
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || ready !== 1'b0) begin
            bad++; $display("FAIL annul_idle busy=%b ready=%b exp 0 0", busy, ready);
        end
        annul = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            tick();
            if (ready || busy) seen_ready = 1'b1;
        end
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL annul_no_result got=1 exp=0"); end
        run_div(1'b0, 32'd50, 32'd5, e, bc);
        total++; if (e !== 33) begin bad++; $display("FAIL annul_restart_latency got=%0d exp=33", e); end
        total++; if (result !== {32'd0, 32'd10}) begin
            bad++; $display("FAIL annul_restart_result got=%h exp=00000000_0000000a", result);
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b0; opdata1 = 32'd999; opdata2 = 32'd7; start = 1'b1;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL reset_mid busy=%b ready=%b result=%h dz=%b exp all 0", busy, ready, result, div_zero);
        end
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || ready !== 1'b0) begin
            bad++; $display("FAIL reset_mid_after busy=%b ready=%b exp 0 0", busy, ready);
        end
    endtask

    task automatic test_width8();
        int e;
        signed8 = 1'b1; op1_8 = 8'h81; op2_8 = 8'h0A; start8 = 1'b1;
        e = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (ready8) begin
                e = i;
                break;
            end
        end
        total++; if (e !== 9) begin bad++; $display("FAIL w8_latency got=%0d exp=9", e); end
        total++; if (result8 !== 16'hF9F4) begin bad++; $display("FAIL w8_result got=%h exp=f9f4", result8); end
        start8 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundary();
        test_annul();
        test_reset_mid();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Parametrised multi-cycle restoring divider for the MIPS execute stage. It generalises the fixed 32-bit divider with configurable operand width, a divide-by-zero flag, a working annul path and a busy indication.
- The EX stage drives the operands and start. EX stalls via ctrl until ready_o; the result feeds HI/LO (remainder to HI, quotient to LO).

Parameters:
- WIDTH, 32, operand width in bits; legal values 4..64.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset (one clock domain, async assert, active-low).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; level, held by EX until result consumed.
- annul_i  input  1  abort current operation (exception/flush).
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result valid.
- busy_o  output  1  operation in progress (DZERO or BUSY state).
- div_zero_o  output  1  qualifies ready_o: divisor was zero.

Behaviour:
- Reset values: result_o=0, ready_o=0, busy_o=0, div_zero_o=0, state=IDLE, counter=0.
- States: IDLE, DZERO, BUSY, DONE.
- IDLE: if start_i=1 and annul_i=0, latch operands and mode.
  - Divisor==0 → DZERO.
  - Otherwise compute magnitudes: in signed mode negate negative operands (two's complement, WIDTH bits). Record q_neg=sign1^sign2 and r_neg=sign1, clear the counter, → BUSY.
  - start_i with annul_i=1 is ignored.
- DZERO: one cycle → DONE with result_o=0 and div_zero_o=1.
- BUSY: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude with WIDTH+1-bit arithmetic. If no borrow, keep the difference and set the quotient LSB to 1; else set it to 0.
  - Counter increments each cycle. After exactly WIDTH BUSY cycles → DONE.
  - On the transition, apply sign fix-up: quotient negated if q_neg, remainder negated if r_neg. Load result_o and set div_zero_o=0.
- Latency: start sampled at edge 0. ready_o is high after edge WIDTH+1 (BUSY occupies edges 1..WIDTH; the DONE load happens at edge WIDTH+1). Divide-by-zero: ready_o high after edge 2.
- DONE: ready_o=1 and result_o stable while start_i=1. When start_i=0: → IDLE, ready_o=0, result_o cleared to 0, div_zero_o cleared.
- annul_i=1 in BUSY or DZERO: → IDLE next edge. ready_o stays 0, no result is loaded, busy_o=0 next cycle. annul_i in DONE behaves as start_i=0.
- Operand inputs may change after acceptance without effect; the block works only from latched copies.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value (wraps), remainder = 0. No flag.
- Unsigned mode never negates; an MSB=1 operand is treated as a large magnitude.
- busy_o=1 exactly in DZERO and BUSY states.
- Async reset mid-operation returns all state and outputs to reset values immediately. No result is produced.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=32, unsigned, 100 ÷ 7, start held → ready_o rises after 33 edges; result_o = {32'd2, 32'd14}; busy_o high for 32 cycles.
- Signed −7 ÷ 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Then 7 ÷ −2 → quotient −3, remainder +1.
- Divisor 0, dividend 0x1234 → ready_o after 2 edges, div_zero_o=1, result_o=0. Deassert start → ready_o=0 next edge, div_zero_o=0.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF ÷ 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- Annul at BUSY cycle 10 → IDLE next edge, ready_o never asserts. A new start (50 ÷ 5) then completes in 33 edges with quotient 10, remainder 0. Separately, resetn pulsed low mid-BUSY → all outputs 0 immediately.
- WIDTH=8 build: signed 0x81 (−127) ÷ 0x0A → ready after 9 edges; quotient 0xF4 (−12), remainder 0xF9 (−7).
